// File: rtl/display_pkg.sv
// Shared encodings and constants for the display blanking path.
package display_pkg;

   typedef enum logic [1:0] {
      ST_ACTIVE    = 2'd0,
      ST_SAVER     = 2'd1,
      ST_WAKE_PEND = 2'd2
   } state_e;

   localparam int unsigned FRAMES_PER_SEC = 60;

   // Terminal index of an n-frame count; a zero-length count terminates at 0.
   function automatic int unsigned last_idx(input int unsigned n);
      return (n == 0) ? 0 : n - 1;
   endfunction

endpackage

// File: rtl/frame_counter.sv
// Frame counter with clear, tick enable and terminal-count flag; saturating or wrapping.
module frame_counter
   import display_pkg::*;
#(
   parameter int unsigned CNT_W = 12,
   parameter int unsigned LIMIT = 1,
   parameter bit          WRAP  = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic tick,
   output logic term_c
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(last_idx(LIMIT));
   localparam logic [CNT_W-1:0] SAT  = CNT_W'(LIMIT);

   logic [CNT_W-1:0] count;

   assign term_c = (count == LAST);

   // Clear outranks tick; wrap mode returns to 0 after LAST, saturate mode parks at LIMIT.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (tick) begin
         if (WRAP) begin
            count <= term_c ? '0 : count + CNT_W'(1);
         end else if (count != SAT) begin
            count <= count + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/display_blank_ctrl.sv
// Frame-synchronous blank control for the colorizer: screen-saver, blink and force-blank,
// with blank_disp committed only on vsync so a frame is never partly blanked.
module display_blank_ctrl
   import display_pkg::*;
#(
   parameter int unsigned TIMEOUT_FRAMES = 1800,
   parameter int unsigned BLINK_FRAMES   = 30,
   parameter int unsigned CNT_W          = 12
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       vsync_tick,
   input  logic       activity,
   input  logic       blink_en,
   input  logic       force_blank,
   output logic       blank_disp,
   output logic       saver_active,
   output logic [1:0] state_out
);

   localparam bit SAVER_EN = (TIMEOUT_FRAMES != 0);

   state_e state;
   state_e next_state;
   logic   in_active;
   logic   blink_phase;
   logic   next_blink_phase;
   logic   idle_clear;
   logic   blink_clear;
   logic   idle_term_c;
   logic   blink_term_c;
   logic   next_blank;

   assign in_active = (state == ST_ACTIVE);

   // Next-state decode; the unused code 3 falls back to ACTIVE.
   always_comb begin
      next_state = ST_ACTIVE;
      case (state)
         ST_ACTIVE: begin
            if (vsync_tick && !activity && SAVER_EN && idle_term_c) begin
               next_state = ST_SAVER;
            end else begin
               next_state = ST_ACTIVE;
            end
         end
         ST_SAVER:     next_state = activity ? ST_WAKE_PEND : ST_SAVER;
         ST_WAKE_PEND: next_state = vsync_tick ? ST_ACTIVE : ST_WAKE_PEND;
         default:      next_state = ST_ACTIVE;
      endcase
   end

   // Counters only run in ACTIVE; any state change starts them over from 0.
   always_comb begin
      idle_clear  = activity || !in_active || (next_state != ST_ACTIVE);
      blink_clear = !blink_en || !in_active || (next_state != ST_ACTIVE);
   end

   frame_counter #(
      .CNT_W (CNT_W),
      .LIMIT (TIMEOUT_FRAMES),
      .WRAP  (1'b0)
   ) u_idle_cnt (
      .clk    (clk),
      .reset  (reset),
      .clear  (idle_clear),
      .tick   (vsync_tick),
      .term_c (idle_term_c)
   );

   frame_counter #(
      .CNT_W (CNT_W),
      .LIMIT (BLINK_FRAMES),
      .WRAP  (1'b1)
   ) u_blink_cnt (
      .clk    (clk),
      .reset  (reset),
      .clear  (blink_clear),
      .tick   (vsync_tick),
      .term_c (blink_term_c)
   );

   // Blink phase flips each time the blink counter wraps.
   always_comb begin
      next_blink_phase = blink_phase;
      if (blink_clear) begin
         next_blink_phase = 1'b0;
      end else if (vsync_tick && blink_term_c) begin
         next_blink_phase = ~blink_phase;
      end
      next_blank = force_blank || (next_state != ST_ACTIVE) || (blink_en && next_blink_phase);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_ACTIVE;
         blink_phase  <= 1'b0;
         blank_disp   <= 1'b0;
         saver_active <= 1'b0;
      end else begin
         state        <= next_state;
         blink_phase  <= next_blink_phase;
         saver_active <= (next_state != ST_ACTIVE);
         if (vsync_tick) begin
            blank_disp <= next_blank;
         end
      end
   end

   assign state_out = state;

endmodule

// File: tb/tb_display_blank_ctrl.sv
// Directed bench for display_blank_ctrl: TIMEOUT_FRAMES=4, BLINK_FRAMES=2, vsync every 10 clocks.
module tb_display_blank_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       vsync_tick = 1'b0;
   logic       activity = 1'b0;
   logic       blink_en = 1'b0;
   logic       force_blank = 1'b0;
   logic       blank_disp;
   logic       saver_active;
   logic [1:0] state_out;

   int n_cmp = 0;
   int n_bad = 0;

   display_blank_ctrl #(
      .TIMEOUT_FRAMES (4),
      .BLINK_FRAMES   (2),
      .CNT_W          (12)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .vsync_tick   (vsync_tick),
      .activity     (activity),
      .blink_en     (blink_en),
      .force_blank  (force_blank),
      .blank_disp   (blank_disp),
      .saver_active (saver_active),
      .state_out    (state_out)
   );

   always #5 clk = ~clk;

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cycle();
   endtask

   task automatic tick();
      vsync_tick = 1'b1;
      cycle();
      vsync_tick = 1'b0;
   endtask

   task automatic tick_act();
      vsync_tick = 1'b1;
      activity   = 1'b1;
      cycle();
      vsync_tick = 1'b0;
      activity   = 1'b0;
   endtask

   task automatic pulse_act();
      activity = 1'b1;
      cycle();
      activity = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      n_cmp++; if (state_out !== 2'd0) begin n_bad++; $display("FAIL rst0_state got %0d exp 0", state_out); end
      n_cmp++; if (blank_disp !== 1'b0) begin n_bad++; $display("FAIL rst0_blank got %b exp 0", blank_disp); end
      n_cmp++; if (saver_active !== 1'b0) begin n_bad++; $display("FAIL rst0_saver got %b exp 0", saver_active); end
      repeat (4) begin
         idle(9);
         tick();
      end
      n_cmp++; if (state_out !== 2'd1) begin n_bad++; $display("FAIL pre_rst_state got %0d exp 1", state_out); end
      n_cmp++; if (blank_disp !== 1'b1) begin n_bad++; $display("FAIL pre_rst_blank got %b exp 1", blank_disp); end
      idle(3);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      n_cmp++; if (state_out !== 2'd0) begin n_bad++; $display("FAIL rst_mid_state got %0d exp 0", state_out); end
      n_cmp++; if (blank_disp !== 1'b0) begin n_bad++; $display("FAIL rst_mid_blank got %b exp 0", blank_disp); end
      n_cmp++; if (saver_active !== 1'b0) begin n_bad++; $display("FAIL rst_mid_saver got %b exp 0", saver_active); end
      idle(5);
      tick();
      n_cmp++; if (blank_disp !== 1'b0) begin n_bad++; $display("FAIL rst_tick1_blank got %b exp 0", blank_disp); end
      n_cmp++; if (state_out !== 2'd0) begin n_bad++; $display("FAIL rst_tick1_state got %0d exp 0", state_out); end
   endtask

   task automatic test_timeout();
      idle(9);
      tick();
      idle(9);
      tick_act();
      n_cmp++; if (state_out !== 2'd0) begin n_bad++; $display("FAIL to_act_state got %0d exp 0", state_out); end
      for (int i = 1; i <= 3; i++) begin
         idle(9);
         tick();
         n_cmp++; if (state_out !== 2'd0) begin n_bad++; $display("FAIL to_tick%0d_state got %0d exp 0", i, state_out); end
         n_cmp++; if (blank_disp !== 1'b0) begin n_bad++; $display("FAIL to_tick%0d_blank got %b exp 0", i, blank_disp); end
      end
      idle(9);
      n_cmp++; if (saver_active !== 1'b0) begin n_bad++; $display("FAIL to_pre4_saver got %b exp 0", saver_active); end
      tick();
      n_cmp++; if (state_out !== 2'd1) begin n_bad++; $display("FAIL to_tick4_state got %0d exp 1", state_out); end
      n_cmp++; if (blank_disp !== 1'b1) begin n_bad++; $display("FAIL to_tick4_blank got %b exp 1", blank_disp); end
      n_cmp++; if (saver_active !== 1'b1) begin n_bad++; $display("FAIL to_tick4_saver got %b exp 1", saver_active); end
   endtask

   task automatic test_wake();
      idle(2);
      pulse_act();
      n_cmp++; if (state_out !== 2'd2) begin n_bad++; $display("FAIL wake_state got %0d exp 2", state_out); end
      n_cmp++; if (saver_active !== 1'b1) begin n_bad++; $display("FAIL wake_saver got %b exp 1", saver_active); end
      n_cmp++; if (blank_disp !== 1'b1) begin n_bad++; $display("FAIL wake_blank got %b exp 1", blank_disp); end
      idle(2);
      pulse_act();
      idle(3);
      n_cmp++; if (state_out !== 2'd2) begin n_bad++; $display("FAIL wake_react_state got %0d exp 2", state_out); end
      n_cmp++; if (blank_disp !== 1'b1) begin n_bad++; $display("FAIL wake_hold_blank got %b exp 1", blank_disp); end
      tick();
      n_cmp++; if (state_out !== 2'd0) begin n_bad++; $display("FAIL wake_tick_state got %0d exp 0", state_out); end
      n_cmp++; if (blank_disp !== 1'b0) begin n_bad++; $display("FAIL wake_tick_blank got %b exp 0", blank_disp); end
      n_cmp++; if (saver_active !== 1'b0) begin n_bad++; $display("FAIL wake_tick_saver got %b exp 0", saver_active); end
   endtask

   task automatic test_wake_on_tick();
      repeat (4) begin
         idle(9);
         tick();
      end
      n_cmp++; if (state_out !== 2'd1) begin n_bad++; $display("FAIL wot_saver_state got %0d exp 1", state_out); end
      idle(9);
      tick_act();
      n_cmp++; if (state_out !== 2'd2) begin n_bad++; $display("FAIL wot_state got %0d exp 2", state_out); end
      n_cmp++; if (blank_disp !== 1'b1) begin n_bad++; $display("FAIL wot_blank got %b exp 1", blank_disp); end
      idle(9);
      n_cmp++; if (blank_disp !== 1'b1) begin n_bad++; $display("FAIL wot_frame_blank got %b exp 1", blank_disp); end
      tick();
      n_cmp++; if (state_out !== 2'd0) begin n_bad++; $display("FAIL wot_tick_state got %0d exp 0", state_out); end
      n_cmp++; if (blank_disp !== 1'b0) begin n_bad++; $display("FAIL wot_tick_blank got %b exp 0", blank_disp); end
   endtask

   task automatic test_blink();
      logic exp_pat [6];
      exp_pat = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      blink_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         idle(9);
         tick_act();
         n_cmp++; if (blank_disp !== exp_pat[i]) begin n_bad++; $display("FAIL blink_tick%0d got %b exp %b", i + 1, blank_disp, exp_pat[i]); end
      end
      idle(4);
      blink_en = 1'b0;
      idle(5);
      n_cmp++; if (blank_disp !== 1'b1) begin n_bad++; $display("FAIL blink_off_hold got %b exp 1", blank_disp); end
      tick_act();
      n_cmp++; if (blank_disp !== 1'b0) begin n_bad++; $display("FAIL blink_off_tick got %b exp 0", blank_disp); end
   endtask

   task automatic test_force();
      idle(1);
      force_blank = 1'b1;
      idle(8);
      n_cmp++; if (blank_disp !== 1'b0) begin n_bad++; $display("FAIL force_pre got %b exp 0", blank_disp); end
      tick_act();
      n_cmp++; if (blank_disp !== 1'b1) begin n_bad++; $display("FAIL force_on got %b exp 1", blank_disp); end
      force_blank = 1'b0;
      idle(9);
      n_cmp++; if (blank_disp !== 1'b1) begin n_bad++; $display("FAIL force_off_hold got %b exp 1", blank_disp); end
      tick_act();
      n_cmp++; if (blank_disp !== 1'b0) begin n_bad++; $display("FAIL force_off got %b exp 0", blank_disp); end
      force_blank = 1'b1;
      repeat (4) begin
         idle(9);
         tick();
      end
      n_cmp++; if (state_out !== 2'd1) begin n_bad++; $display("FAIL force_saver_state got %0d exp 1", state_out); end
      idle(1);
      force_blank = 1'b0;
      idle(8);
      tick();
      n_cmp++; if (blank_disp !== 1'b1) begin n_bad++; $display("FAIL force_off_saver got %b exp 1", blank_disp); end
      n_cmp++; if (state_out !== 2'd1) begin n_bad++; $display("FAIL force_off_saver_state got %0d exp 1", state_out); end
   endtask

   initial begin
      test_reset();
      test_timeout();
      test_wake();
      test_wake_on_tick();
      test_blink();
      test_force();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/display_blank_ctrl.md
Name: display_blank_ctrl

Overview:
Frame-synchronous controller that generates the blank_disp input of the VGA colorizer stage.
It owns three blanking sources: a screen-saver after an inactivity timeout, a periodic blink, and a software force-blank.
All changes to blank_disp are committed only on the vertical-sync tick, so a frame is never partly blanked.
It sits between the display timing generator (vsync_tick) and the colorizer, and is configured from the CPU I/O registers.

Parameters:
TIMEOUT_FRAMES, 1800, idle frames before screen-saver engages (30 s at 60 Hz); 0 disables the saver.
BLINK_FRAMES, 30, frames per blink half-period; must be >= 1.
CNT_W, 12, counter width; must hold max(TIMEOUT_FRAMES, BLINK_FRAMES).

Ports:
clk  in  1  system clock (pixel-domain clock shared with the timing generator).
reset  in  1  synchronous, active-high reset.
vsync_tick  in  1  one-cycle pulse at the start of each vertical blanking interval.
activity  in  1  one-cycle pulse on any user input (buttons, switches, keyboard).
blink_en  in  1  level; enables periodic blinking while awake.
force_blank  in  1  level; software blank request.
blank_disp  out  1  registered; 1 = colorizer outputs black.
saver_active  out  1  registered; 1 while state is SAVER or WAKE_PEND.
state_out  out  2  current FSM state, for debug and for the CPU status register.

Behaviour:
Reset (synchronous, highest priority):
- state=ACTIVE, idle_cnt=0, blink_cnt=0, blink_phase=0, wake_req=0.
- blank_disp=0, saver_active=0.

FSM states (2-bit): ACTIVE=0, SAVER=1, WAKE_PEND=2; code 3 is illegal and recovers to ACTIVE on the next clock.

ACTIVE:
- activity=1 clears idle_cnt to 0 on the same edge, with or without vsync_tick.
- vsync_tick=1 with activity=0 increments idle_cnt, saturating at TIMEOUT_FRAMES.
- vsync_tick=1, activity=0, TIMEOUT_FRAMES!=0 and idle_cnt==TIMEOUT_FRAMES-1: go to SAVER. The same edge clears idle_cnt, blink_cnt and blink_phase.

SAVER:
- activity=1 goes to WAKE_PEND, including when vsync_tick is also 1 that cycle. Waking therefore always waits for a later vsync_tick.
- vsync_tick alone: stay in SAVER.

WAKE_PEND:
- Next vsync_tick goes to ACTIVE; idle_cnt=0, blink_cnt=0, blink_phase=0.
- Further activity pulses have no effect.

Blink (only in ACTIVE):
- blink_en=0 forces blink_cnt=0 and blink_phase=0 on every clock, independent of vsync.
- blink_en=1 and vsync_tick=1: blink_cnt increments. At BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.

blank_disp update:
- Loaded only on a clock with vsync_tick=1 (or by reset); it holds between ticks.
- next = force_blank | next_state!=ACTIVE | (blink_en & next_blink_phase).
- force_blank changes between ticks therefore take effect at the next tick (latency 1 to 2 frames, by design).
- The blank_disp register updates on the same edge as the state register; no extra pipeline stage.

saver_active:
- Registered from next_state on every clock, not vsync-gated, so the CPU sees the wake request immediately.

Arithmetic:
- All counters are unsigned CNT_W bits.
- Comparisons are made against the parameter minus 1, computed at elaboration.
- No counter exceeds its terminal value.

Decomposition:
Shared package display_pkg holds:
- the state encoding constants ST_ACTIVE, ST_SAVER, ST_WAKE_PEND;
- the default frame-rate constant FRAMES_PER_SEC=60.

One natural sub-module is frame_counter. It is a CNT_W-bit counter with clear, tick enable, terminal-count output and a mode select (saturate or wrap). It is instantiated twice: idle_cnt in saturate mode, blink_cnt in wrap mode.

Test Plan:
Use TIMEOUT_FRAMES=4, BLINK_FRAMES=2, and vsync_tick every 10 clocks in all scenarios.
1. Reset mid-frame with blank_disp=1 and state SAVER, reset held 1 clock -> next cycle state_out=0, blank_disp=0, saver_active=0; the first blank change occurs only at a later tick.
2. No activity for 4 ticks -> on the 4th tick edge state_out=1 and blank_disp=1. Activity on tick 3 instead -> idle_cnt=0, and the saver engages 4 ticks later.
3. In SAVER, activity pulse 3 clocks after a tick -> saver_active=1, state_out=2 next clock, blank_disp stays 1; at the next tick state_out=0 and blank_disp=0.
4. In SAVER, activity coincident with vsync_tick -> state_out=2, blank_disp stays 1 for one more full frame, then 0 at the following tick.
5. blink_en=1 in ACTIVE, activity every tick -> blank_disp pattern per tick 0,1,1,0,0,1... (toggles every 2 ticks). blink_en dropped mid-frame -> blank_disp=0 at the next tick.
6. force_blank raised 2 clocks after a tick -> blank_disp stays 0 until the next tick, then 1. Lowered -> 0 at the following tick, unless the state is SAVER.
